// File: rtl/sd_spi_pkg.sv
// Shared state codes, frame phases and SD framing constants for the SD command
// sequencer and its SPI byte handshake.
package sd_spi_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_CONF      = 3'd1;
    localparam logic [2:0] ST_TX_STROBE = 3'd2;
    localparam logic [2:0] ST_TX_ACK    = 3'd3;
    localparam logic [2:0] ST_TX_WAIT   = 3'd4;
    localparam logic [2:0] ST_NEXT      = 3'd5;
    localparam logic [2:0] ST_DONE      = 3'd6;

    typedef enum logic [1:0] {
        PH_FRAME,
        PH_POLL,
        PH_RESP,
        PH_TRAIL
    } phase_t;

    localparam logic [7:0] SD_DUMMY_BYTE = 8'hFF;
    localparam int         SD_FRAME_LEN  = 6;
    localparam logic [1:0] SD_START_BITS = 2'b01;

endpackage

// File: rtl/sd_spi_byte_if.sv
// One-byte handshake with the SPI master: strobe, wait for busy to rise, then
// wait for it to fall and capture the received byte. Also issues config writes.
module sd_spi_byte_if
    import sd_spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       conf,
    input  logic [7:0] byte_in,
    output logic       ack,
    output logic [7:0] byte_out,
    output logic       spi_w_data,
    output logic       spi_w_conf,
    output logic [7:0] spi_data_in,
    input  logic       spi_busy,
    input  logic [7:0] spi_data_out
);

    logic [2:0] state;

    // ack fires in the single cycle where the master has finished the byte
    assign ack = (state == ST_TX_WAIT) && !spi_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            spi_w_data  <= 1'b0;
            spi_w_conf  <= 1'b0;
            spi_data_in <= SD_DUMMY_BYTE;
        end else begin
            spi_w_data <= 1'b0;
            spi_w_conf <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        spi_data_in <= byte_in;
                        spi_w_data  <= 1'b1;
                        state       <= ST_TX_STROBE;
                    end else if (conf) begin
                        spi_data_in <= byte_in;
                        spi_w_conf  <= 1'b1;
                    end
                end
                ST_TX_STROBE: state <= ST_TX_ACK;
                ST_TX_ACK:    if (spi_busy) state <= ST_TX_WAIT;
                ST_TX_WAIT:   if (!spi_busy) state <= ST_IDLE;
                default:      state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ack) byte_out <= spi_data_out;
    end

endmodule

// File: rtl/sd_cmd_ctrl.sv
// SD command sequencer: sends a 6-byte command frame, polls for R1, collects
// optional trailing response bytes and sends one release byte before finishing.
module sd_cmd_ctrl
    import sd_spi_pkg::*;
#(
    parameter int NCR_MAX  = 8,
    parameter int RESP_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [5:0]            cmd_idx,
    input  logic [31:0]           cmd_arg,
    input  logic [6:0]            cmd_crc,
    input  logic [2:0]            resp_len,
    input  logic                  div_we,
    input  logic [7:0]            div,
    output logic                  ready,
    output logic                  done,
    output logic                  timeout,
    output logic [7:0]            r1,
    output logic [8*RESP_MAX-1:0] resp_data,
    output logic [7:0]            spi_data_in,
    output logic                  spi_w_data,
    output logic                  spi_w_conf,
    output logic                  spi_ss,
    input  logic                  spi_busy,
    input  logic [7:0]            spi_data_out
);

    localparam int         RW         = 8 * RESP_MAX;
    localparam logic [7:0] POLL_LAST  = 8'(NCR_MAX - 1);
    localparam logic [2:0] RESP_CAP   = 3'(RESP_MAX);
    localparam logic [2:0] FRAME_LAST = 3'(SD_FRAME_LEN - 1);

    logic [2:0]  state;
    phase_t      phase;
    logic [2:0]  byte_cnt;
    logic [7:0]  poll_cnt;
    logic [2:0]  resp_cnt;
    logic [2:0]  resp_len_q;
    logic [39:0] frame_q;

    logic        tx_req;
    logic        tx_conf;
    logic        tx_ack;
    logic [7:0]  tx_byte;
    logic [7:0]  rx_byte;
    logic        accept_div;
    logic        accept_start;

    assign accept_div   = (state == ST_IDLE) && div_we;
    assign accept_start = (state == ST_IDLE) && start && !div_we;

    // The first frame byte comes straight from the inputs so it strobes on the accept edge
    always_comb begin
        tx_req  = 1'b0;
        tx_conf = accept_div;
        tx_byte = SD_DUMMY_BYTE;
        if (accept_div) begin
            tx_byte = div;
        end else if (accept_start) begin
            tx_req  = 1'b1;
            tx_byte = {SD_START_BITS, cmd_idx};
        end else if (state == ST_NEXT && phase != PH_TRAIL) begin
            tx_req = 1'b1;
            if (phase == PH_FRAME && byte_cnt != FRAME_LAST) tx_byte = frame_q[39:32];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            phase     <= PH_FRAME;
            ready     <= 1'b1;
            done      <= 1'b0;
            timeout   <= 1'b0;
            r1        <= SD_DUMMY_BYTE;
            resp_data <= '0;
            spi_ss    <= 1'b1;
            byte_cnt  <= 3'd0;
            poll_cnt  <= 8'd0;
            resp_cnt  <= 3'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept_div) begin
                        state <= ST_CONF;
                        ready <= 1'b0;
                    end else if (accept_start) begin
                        state     <= ST_TX_WAIT;
                        ready     <= 1'b0;
                        spi_ss    <= 1'b0;
                        timeout   <= 1'b0;
                        resp_data <= '0;
                        phase     <= PH_FRAME;
                        byte_cnt  <= 3'd0;
                        poll_cnt  <= 8'd0;
                        resp_cnt  <= 3'd0;
                    end
                end
                ST_CONF: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
                ST_TX_WAIT: if (tx_ack) state <= ST_NEXT;
                ST_NEXT: begin
                    state <= (phase == PH_TRAIL) ? ST_DONE : ST_TX_WAIT;
                    case (phase)
                        PH_FRAME: begin
                            if (byte_cnt == FRAME_LAST) phase <= PH_POLL;
                            else                        byte_cnt <= byte_cnt + 3'd1;
                        end
                        PH_POLL: begin
                            if (!rx_byte[7]) begin
                                r1    <= rx_byte;
                                phase <= (resp_len_q != 3'd0) ? PH_RESP : PH_TRAIL;
                            end else if (poll_cnt == POLL_LAST) begin
                                r1      <= SD_DUMMY_BYTE;
                                timeout <= 1'b1;
                                phase   <= PH_TRAIL;
                            end else begin
                                poll_cnt <= poll_cnt + 8'd1;
                            end
                        end
                        PH_RESP: begin
                            resp_data <= {resp_data[RW-9:0], rx_byte};
                            if (resp_cnt == resp_len_q - 3'd1) phase <= PH_TRAIL;
                            else                               resp_cnt <= resp_cnt + 3'd1;
                        end
                        default: begin
                            done   <= 1'b1;
                            spi_ss <= 1'b1;
                        end
                    endcase
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Remaining frame bytes shift out MSB byte first; first byte was sent from the inputs
    always_ff @(posedge clk) begin
        if (accept_start) begin
            frame_q    <= {cmd_arg, cmd_crc, 1'b1};
            resp_len_q <= (resp_len > RESP_CAP) ? RESP_CAP : resp_len;
        end else if (state == ST_NEXT && phase == PH_FRAME) begin
            frame_q <= {frame_q[31:0], 8'h00};
        end
    end

    sd_spi_byte_if u_byte_if (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (tx_req),
        .conf         (tx_conf),
        .byte_in      (tx_byte),
        .ack          (tx_ack),
        .byte_out     (rx_byte),
        .spi_w_data   (spi_w_data),
        .spi_w_conf   (spi_w_conf),
        .spi_data_in  (spi_data_in),
        .spi_busy     (spi_busy),
        .spi_data_out (spi_data_out)
    );

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// Directed bench for sd_cmd_ctrl with a small SPI master model that records
// every transmitted byte and replays a queue of card responses.
module tb_sd_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  cmd_idx = '0;
    logic [31:0] cmd_arg = '0;
    logic [6:0]  cmd_crc = '0;
    logic [2:0]  resp_len = '0;
    logic        div_we = 1'b0;
    logic [7:0]  div = '0;
    logic        ready, done, timeout;
    logic [7:0]  r1;
    logic [31:0] resp_data;
    logic [7:0]  spi_data_in;
    logic        spi_w_data, spi_w_conf, spi_ss;
    logic        spi_busy = 1'b0;
    logic [7:0]  spi_data_out = 8'hFF;

    int          n_cmp = 0;
    int          n_err = 0;
    int          busy_cnt = 0;
    int          conf_cnt = 0;
    int          done_cnt = 0;
    logic [7:0]  mosi_q[$];
    logic [7:0]  miso_q[$];
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    sd_cmd_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cmd_idx      (cmd_idx),
        .cmd_arg      (cmd_arg),
        .cmd_crc      (cmd_crc),
        .resp_len     (resp_len),
        .div_we       (div_we),
        .div          (div),
        .ready        (ready),
        .done         (done),
        .timeout      (timeout),
        .r1           (r1),
        .resp_data    (resp_data),
        .spi_data_in  (spi_data_in),
        .spi_w_data   (spi_w_data),
        .spi_w_conf   (spi_w_conf),
        .spi_ss       (spi_ss),
        .spi_busy     (spi_busy),
        .spi_data_out (spi_data_out)
    );

    // SPI master model: busy for 3 cycles per byte; card answers FF during the frame
    always @(posedge clk) begin
        if (!rst_n) begin
            spi_busy <= 1'b0;
            busy_cnt <= 0;
        end else if (spi_w_data) begin
            spi_busy <= 1'b1;
            busy_cnt <= 2;
            if (mosi_q.size() >= 6 && miso_q.size() > 0) spi_data_out <= miso_q.pop_front();
            else                                          spi_data_out <= 8'hFF;
            mosi_q.push_back(spi_data_in);
        end else if (spi_busy) begin
            if (busy_cnt == 0) spi_busy <= 1'b0;
            else               busy_cnt <= busy_cnt - 1;
        end
    end

    always @(posedge clk) begin
        if (spi_w_conf) conf_cnt <= conf_cnt + 1;
        if (done)       done_cnt <= done_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_mosi(input string tag, input logic [7:0] exp[$]);
        logic [31:0] got;
        check_val({tag, " byte count"}, mosi_q.size(), exp.size());
        foreach (exp[i]) begin
            got = (i < mosi_q.size()) ? {24'h0, mosi_q[i]} : 32'hDEAD;
            check_val($sformatf("%s byte %0d", tag, i), got, {24'h0, exp[i]});
        end
    endtask

    task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                           input logic [6:0] crc, input logic [2:0] rlen);
        int d0;
        bit seen;
        mosi_q.delete();
        @(negedge clk);
        cmd_idx  = idx;
        cmd_arg  = arg;
        cmd_crc  = crc;
        resp_len = rlen;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val({tag, " ready low"}, ready, 0);
        check_val({tag, " ss low"}, spi_ss, 0);
        check_val({tag, " first strobe"}, spi_w_data, 1);
        check_val({tag, " first byte"}, spi_data_in, {24'h0, 2'b01, idx});
        d0   = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check_val({tag, " done seen"}, seen, 1);
        check_val({tag, " ss at done"}, spi_ss, 1);
        @(negedge clk);
        check_val({tag, " done single"}, done, 0);
        check_val({tag, " ready after"}, ready, 1);
        @(negedge clk);
        check_val({tag, " done count"}, done_cnt - d0, 1);
    endtask

    initial begin
        int d0;
        int c0;
        // reset
        repeat (3) @(posedge clk);
        #1;
        check_val("rst ready", ready, 1);
        check_val("rst done", done, 0);
        check_val("rst timeout", timeout, 0);
        check_val("rst r1", r1, 32'hFF);
        check_val("rst resp", resp_data, 0);
        check_val("rst data_in", spi_data_in, 32'hFF);
        check_val("rst w_data", spi_w_data, 0);
        check_val("rst w_conf", spi_w_conf, 0);
        check_val("rst ss", spi_ss, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_val("idle ready", ready, 1);
        check_val("idle ss", spi_ss, 1);
        check_val("idle r1", r1, 32'hFF);
        check_val("idle no data strobes", mosi_q.size(), 0);
        check_val("idle no conf strobes", conf_cnt, 0);

        // divider write wins over simultaneous start
        @(negedge clk);
        div_we  = 1'b1;
        div     = 8'h04;
        start   = 1'b1;
        cmd_idx = 6'd0;
        @(posedge clk);
        #1;
        div_we = 1'b0;
        start  = 1'b0;
        check_val("div w_conf", spi_w_conf, 1);
        check_val("div data_in", spi_data_in, 32'h04);
        check_val("div no w_data", spi_w_data, 0);
        check_val("div ready low", ready, 0);
        @(posedge clk);
        #1;
        check_val("div w_conf pulse", spi_w_conf, 0);
        check_val("div ready back", ready, 1);
        repeat (6) @(negedge clk);
        check_val("div conf count", conf_cnt, 1);
        check_val("div start dropped", mosi_q.size(), 0);
        check_val("div ss high", spi_ss, 1);

        // CMD0
        miso_q = '{8'hFF, 8'h01};
        run_cmd("cmd0", 6'd0, 32'h0, 7'h4A, 3'd0);
        check_val("cmd0 r1", r1, 32'h01);
        check_val("cmd0 timeout", timeout, 0);
        check_val("cmd0 resp", resp_data, 0);
        exp_q = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF, 8'hFF};
        check_mosi("cmd0", exp_q);

        // CMD8 with four response bytes
        miso_q = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
        run_cmd("cmd8", 6'd8, 32'h0000_01AA, 7'h43, 3'd4);
        check_val("cmd8 r1", r1, 32'h01);
        check_val("cmd8 timeout", timeout, 0);
        check_val("cmd8 resp", resp_data, 32'h0000_01AA);
        exp_q = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        check_mosi("cmd8", exp_q);

        // resp_len above RESP_MAX clamps to four bytes
        miso_q = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_cmd("clamp", 6'd58, 32'h8000_0000, 7'h7E, 3'd7);
        check_val("clamp r1", r1, 32'h00);
        check_val("clamp resp", resp_data, 32'h1122_3344);
        check_val("clamp byte count", mosi_q.size(), 12);

        // no R1: NCR_MAX polls then trail
        miso_q.delete();
        run_cmd("tmo", 6'd55, 32'h0, 7'h32, 3'd0);
        check_val("tmo r1", r1, 32'hFF);
        check_val("tmo timeout", timeout, 1);
        check_val("tmo resp", resp_data, 0);
        exp_q = '{8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h65,
                  8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        check_mosi("tmo", exp_q);

        // reset during the second poll byte
        miso_q.delete();
        mosi_q.delete();
        @(negedge clk);
        cmd_idx  = 6'd0;
        cmd_arg  = 32'h0;
        cmd_crc  = 7'h4A;
        resp_len = 3'd0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (mosi_q.size() >= 8) break;
            @(negedge clk);
        end
        check_val("mid reached poll 2", mosi_q.size(), 8);
        check_val("mid ss low", spi_ss, 0);
        d0 = done_cnt;
        c0 = mosi_q.size();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_val("mid rst ss", spi_ss, 1);
        check_val("mid rst ready", ready, 1);
        check_val("mid rst done", done, 0);
        check_val("mid rst timeout", timeout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_val("mid no done", done_cnt - d0, 0);
        check_val("mid no more bytes", mosi_q.size(), c0);

        miso_q = '{8'hFF, 8'h01};
        run_cmd("post", 6'd0, 32'h0, 7'h4A, 3'd0);
        check_val("post r1", r1, 32'h01);
        check_val("post timeout", timeout, 0);
        exp_q = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95, 8'hFF, 8'hFF, 8'hFF};
        check_mosi("post", exp_q);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
